// File: rtl/mem_array.sv
// 16x16 flop-based single-bit store with a registered read port, synchronous write and row clear.
// Optional MEM_ARRAY_PARITY_EN adds a registered per-row XOR output sampled alongside the read.
module mem_array #(
  parameter int ROW_W        = 4,
  parameter int COL_W        = 4,
  parameter int INIT_CHECKER = 1
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic [ROW_W-1:0] _row,
  input  logic [COL_W-1:0] _column,
  input  logic             _we,
  input  logic             _wdata,
  input  logic             _row_clear,
  output logic             _value
`ifdef MEM_ARRAY_PARITY_EN
  ,
  output logic             _row_parity
`endif
);

  localparam int ROWS = 1 << ROW_W;
  localparam int COLS = 1 << COL_W;

  logic [COLS-1:0] cells_q [ROWS];
  logic [COLS-1:0] cells_d [ROWS];
  logic            value_q;
  logic            value_d;

  // Reset image of one row: checkerboard r[0]^c[0], or all zeros.
  function automatic logic [COLS-1:0] init_row(input int r);
    logic [COLS-1:0] bits;
    bits = '0;
    for (int c = 0; c < COLS; c++) begin
      if (INIT_CHECKER != 0) begin
        bits[c] = r[0] ^ c[0];
      end
    end
    return bits;
  endfunction

  // Reads use pre-edge contents; row clear overrides a simultaneous write.
  always_comb begin
    cells_d = cells_q;
    value_d = cells_q[_row][_column];
    if (_row_clear) begin
      cells_d[_row] = '0;
    end else if (_we) begin
      cells_d[_row][_column] = _wdata;
    end
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      for (int r = 0; r < ROWS; r++) begin
        cells_q[r] <= init_row(r);
      end
      value_q <= 1'b0;
    end else begin
      cells_q <= cells_d;
      value_q <= value_d;
    end
  end

  assign _value = value_q;

`ifdef MEM_ARRAY_PARITY_EN
  logic row_parity_q;
  logic row_parity_d;

  always_comb begin
    row_parity_d = ^cells_q[_row];
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      row_parity_q <= 1'b0;
    end else begin
      row_parity_q <= row_parity_d;
    end
  end

  assign _row_parity = row_parity_q;
`endif

endmodule

// File: tb/tb_mem_array.sv
// Bench for mem_array: a bit-map model updated on each rising edge, a per-cycle compare process,
// directed checks with literal expectations, and a randomized read/write/row-clear run.
module tb_mem_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row = '0;
  logic [3:0] col = '0;
  logic       we = 1'b0;
  logic       wdata = 1'b0;
  logic       row_clear = 1'b0;
  logic       value;
`ifdef MEM_ARRAY_PARITY_EN
  logic       row_parity;
`endif

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Model state: one 16-bit word per row, bit c is column c.
  logic [15:0] mem [16];
  logic        exp_value;
  logic        exp_parity;

  mem_array dut (
    ._clock     (clk),
    ._reset     (rst_n),
    ._row       (row),
    ._column    (col),
    ._we        (we),
    ._wdata     (wdata),
    ._row_clear (row_clear),
    ._value     (value)
`ifdef MEM_ARRAY_PARITY_EN
    ,
    ._row_parity(row_parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] checker_row(input int r);
    return (r % 2 == 1) ? 16'h5555 : 16'hAAAA;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) mem[r] = checker_row(r);
      exp_value  = 1'b0;
      exp_parity = 1'b0;
    end else begin
      exp_value  = mem[row][col];
      exp_parity = ^mem[row];
      if (row_clear) mem[row] = 16'h0000;
      else if (we)   mem[row][col] = wdata;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      tests++;
      if (value !== exp_value) begin
        fails++;
        $display("FAIL model_value t=%0t row=%0d col=%0d got=%b exp=%b", $time, row, col, value, exp_value);
      end
`ifdef MEM_ARRAY_PARITY_EN
      tests++;
      if (row_parity !== exp_parity) begin
        fails++;
        $display("FAIL model_parity t=%0t row=%0d got=%b exp=%b", $time, row, row_parity, exp_parity);
      end
`endif
    end
  end

  task automatic check_lit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  // Present inputs right after a falling edge; return after the next falling edge.
  task automatic drive(input int r, input int c, input bit w, input bit wd, input bit clr);
    row       = r[3:0];
    col       = c[3:0];
    we        = w;
    wdata     = wd;
    row_clear = clr;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check_lit("reset_value", value, 1'b0);

    row = 4'd1; col = 4'd5;
    rst_n = 1'b1;
    @(negedge clk);
    check_lit("read_1_5", value, 1'b0);
    drive(1, 4, 0, 0, 0);   check_lit("read_1_4", value, 1'b1);
    drive(0, 15, 0, 0, 0);  check_lit("read_0_15", value, 1'b1);
    drive(15, 15, 0, 0, 0); check_lit("read_15_15", value, 1'b0);

    drive(1, 5, 1, 1, 0);   check_lit("write_old", value, 1'b0);
    drive(1, 5, 0, 0, 0);   check_lit("write_new", value, 1'b1);

    drive(1, 4, 1, 1, 1);   check_lit("clear_old", value, 1'b1);
    drive(1, 4, 0, 0, 0);   check_lit("clear_1_4", value, 1'b0);
    drive(1, 5, 0, 0, 0);   check_lit("clear_1_5", value, 1'b0);
    drive(2, 5, 0, 0, 0);   check_lit("clear_2_5", value, 1'b1);

    drive(15, 0, 1, 0, 0);  check_lit("w15_0_old", value, 1'b1);
    drive(15, 0, 0, 0, 0);  check_lit("read_15_0", value, 1'b0);
    drive(14, 0, 0, 0, 0);  check_lit("read_14_0", value, 1'b0);
    drive(15, 1, 0, 0, 0);  check_lit("read_15_1", value, 1'b0);
    drive(14, 1, 0, 0, 0);  check_lit("read_14_1", value, 1'b1);

`ifdef MEM_ARRAY_PARITY_EN
    drive(3, 0, 0, 0, 0);   check_lit("par_row3", row_parity, 1'b0);
    drive(3, 0, 1, 0, 0);   check_lit("par_row3_old", row_parity, 1'b0);
    drive(3, 0, 0, 0, 0);   check_lit("par_row3_odd", row_parity, 1'b1);
    drive(3, 0, 0, 0, 1);   check_lit("par_clear_old", row_parity, 1'b1);
    drive(3, 0, 0, 0, 0);   check_lit("par_cleared", row_parity, 1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 15),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 11) == 0));
    end

    // Mid-run asynchronous reset, with a write pending while reset is low.
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);   check_lit("pre_reset_0_1", value, 1'b0);
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 0, 0, 0);   check_lit("pre_reset_set", value, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_lit("async_reset_value", value, 1'b0);
    row = 4'd1; col = 4'd5; we = 1'b1; wdata = 1'b1; row_clear = 1'b0;
    repeat (2) @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_lit("restore_1_5", value, 1'b0);
    drive(1, 4, 0, 0, 0);   check_lit("restore_1_4", value, 1'b1);
    drive(15, 0, 0, 0, 0);  check_lit("restore_15_0", value, 1'b1);

    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 15), $urandom_range(0, 15),
            ($urandom_range(0, 1) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0));
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
